carry_select_adder_bec: RTL and testbench
=========================================

Name: carry_select_adder_bec

Overview:
- 16-bit square-root carry-select adder (CSLA) that uses a Binary-to-Excess-1 Converter (BEC) in place of the duplicated carry-in=1 ripple adder, for lower area and power.
- Combinational add core with registered outputs: one clock, synchronous active-high reset.
- Used as a general-purpose datapath adder: {cout,sum} = a + b + cin.

Parameters:
- WIDTH, 16, operand width; only 16 is supported, because the group partition below is fixed.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- a    input  16  operand A (unsigned)
- b    input  16  operand B (unsigned)
- cin  input  1  carry-in
- cout output 1  registered carry-out (bit 16 of the result)
- sum  output 16  registered sum bits [15:0]

Behaviour:
- Reset: on a rising clk edge with rst=1, sum <= 16'h0000 and cout <= 0. rst has priority over new data.
- Latency: exactly 1 cycle. Inputs are sampled at every rising edge with rst=0. {cout,sum} then equals a+b+cin of that edge, mod 2^17.
- No handshake or valid signal. A new operand set can be accepted every cycle (full throughput).
- Reset mid-stream: the result of the operands sampled on the reset edge is discarded. The edge after reset deasserts produces a normal result.
- Arithmetic is unsigned. Overflow appears only in cout; there is no signed overflow flag.
- Group partition, LSB first: G0=[1:0], G1=[3:2], G2=[6:4], G3=[10:7], G4=[15:11] (sizes 2,2,3,4,5).
- G0: plain 2-bit ripple-carry adder (RCA) with carry-in = cin; it produces c1.
- Each group Gk (k>=1) of size n:
  - An n-bit RCA with carry-in=0 produces {c0_k, s0_k} (n+1 bits).
  - An (n+1)-bit BEC computes {c1_k, s1_k} = {c0_k, s0_k} + 1.
  - A 2:1 mux with select = carry out of the previous group picks {c0_k,s0_k} when the select is 0, and the BEC output when it is 1.
  - The mux output carry feeds the next group's select.
- The G4 mux carry is cout.
- The BEC is pure logic. Bit0 = ~x0. Bit i = xi ^ (x0 & ... & x(i-1)).
- The whole add path is combinational between the input sampling edge and the output register. No internal pipelining.
- The bit-accurate result must match a behavioural a+b+cin for all inputs. The CSLA/BEC structure is a required implementation detail and must not be replaced by a synthesized '+'.

Decomposition:
- Shared package: the WIDTH constant (16) and the group boundary constants (2,2,3,4,5 and their bit offsets).
- Sub-module bec_n (parameterised width, 3 to 6 bits), a pure combinational excess-1 converter, instantiated once per group G1..G4.
- Ripple adders and muxes stay inline or as a small full_adder cell.

Test Plan:
- Reset: assert rst for 2 cycles with random a/b/cin -> sum=16'h0000, cout=0 on each of those edges. After release, outputs track inputs with 1-cycle latency.
- a=16'h001F, b=16'h000C, cin=0 -> next cycle sum=16'h002B, cout=0.
- a=16'hC61F, b=16'h018C, cin=1 -> sum=16'hC7AC, cout=0.
- a=16'hFFFF, b=16'h0000, cin=1 -> sum=16'h0000, cout=1. This is a full carry ripple through every BEC/mux stage.
- a=16'h9249, b=16'h9249, cin=1 -> sum=16'h2493, cout=1.
- Back-to-back random stimulus, 10k cycles, plus corners (0+0+0, FFFF+FFFF+1 -> sum=16'hFFFF cout=1, and carries landing exactly on group boundaries at bits 1, 3, 6, 10) -> every cycle {cout,sum} equals the previous cycle's a+b+cin.

Source files
------------

// File: rtl/carry_select_adder_bec_pkg.sv
// Shared constants for the 16-bit square-root carry-select adder.
// Groups run LSB first at 2,2,3,4,5 bits.
package carry_select_adder_bec_pkg;
  localparam int WIDTH = 16;

  localparam int G0_W = 2;
  localparam int G1_W = 2;
  localparam int G2_W = 3;
  localparam int G3_W = 4;
  localparam int G4_W = 5;

  localparam int G0_LSB = 0;
  localparam int G1_LSB = 2;
  localparam int G2_LSB = 4;
  localparam int G3_LSB = 7;
  localparam int G4_LSB = 11;

  function automatic int grp_w(input int k);
    case (k)
      0:       return G0_W;
      1:       return G1_W;
      2:       return G2_W;
      3:       return G3_W;
      4:       return G4_W;
      default: return 0;
    endcase
  endfunction

  function automatic int grp_lsb(input int k);
    case (k)
      0:       return G0_LSB;
      1:       return G1_LSB;
      2:       return G2_LSB;
      3:       return G3_LSB;
      4:       return G4_LSB;
      default: return 0;
    endcase
  endfunction
endpackage

// File: rtl/carry_select_adder_bec_bec_n.sv
// Binary-to-excess-1 converter: y = x + 1 (mod 2^W), purely combinational.
// Replaces the carry-in=1 ripple adder of a classic carry-select group.
module bec_n #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  always_comb begin
    logic all_ones;
    all_ones = 1'b1;
    y        = '0;
    for (int i = 0; i < W; i++) begin
      y[i]     = x[i] ^ all_ones;
      all_ones = all_ones & x[i];
    end
  end
endmodule

// File: rtl/carry_select_adder_bec.sv
// 16-bit square-root CSLA with BEC groups; {cout,sum} = a+b+cin, registered (1 cycle).
// No handshake: accepts a new operand set every cycle, sync active-high reset clears outputs.
module carry_select_adder_bec #(
  parameter int WIDTH = carry_select_adder_bec_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             cout,
  output logic [WIDTH-1:0] sum
);
  import carry_select_adder_bec_pkg::*;

  logic [G0_W-1:0]  g0_s;
  logic             g0_c;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;

  always_comb begin : g0_rca
    logic c;
    c    = cin;
    g0_s = '0;
    for (int i = 0; i < G0_W; i++) begin
      g0_s[i] = a[G0_LSB+i] ^ b[G0_LSB+i] ^ c;
      c       = (a[G0_LSB+i] & b[G0_LSB+i]) | (c & (a[G0_LSB+i] ^ b[G0_LSB+i]));
    end
    g0_c = c;
  end

  // Upper groups never see the real carry: each precomputes both outcomes in parallel.
  for (genvar k = 1; k < 5; k++) begin : g_grp
    localparam int N = grp_w(k);
    localparam int L = grp_lsb(k);

    logic [N:0] s0;
    logic [N:0] s1;

    always_comb begin : rca0
      logic c;
      c  = 1'b0;
      s0 = '0;
      for (int i = 0; i < N; i++) begin
        s0[i] = a[L+i] ^ b[L+i] ^ c;
        c     = (a[L+i] & b[L+i]) | (c & (a[L+i] ^ b[L+i]));
      end
      s0[N] = c;
    end

    bec_n #(.W(N + 1)) u_bec (
      .x (s0),
      .y (s1)
    );
  end

  always_comb begin : select_chain
    logic c;
    sum_d                  = '0;
    sum_d[G0_LSB +: G0_W]  = g0_s;
    c                      = g0_c;
    {c, sum_d[G1_LSB +: G1_W]} = c ? g_grp[1].s1 : g_grp[1].s0;
    {c, sum_d[G2_LSB +: G2_W]} = c ? g_grp[2].s1 : g_grp[2].s0;
    {c, sum_d[G3_LSB +: G3_W]} = c ? g_grp[3].s1 : g_grp[3].s0;
    {c, sum_d[G4_LSB +: G4_W]} = c ? g_grp[4].s1 : g_grp[4].s0;
    cout_d                 = c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_carry_select_adder_bec.sv
// Scoreboard bench: driver pushes a+b+cin (or 0 under reset) per cycle, monitor pops one per cycle.
module tb_carry_select_adder_bec;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        cout;
  logic [15:0] sum;

  always #5 clk = ~clk;

  carry_select_adder_bec dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .cout (cout),
    .sum  (sum)
  );

  logic [16:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic drive(input logic r, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic tc, input string nm);
    logic [16:0] expv;
    rst = r;
    a   = ta;
    b   = tb_;
    cin = tc;
    if (r) expv = 17'd0;
    else   expv = {1'b0, ta} + {1'b0, tb_} + {16'd0, tc};
    exp_q.push_back(expv);
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [16:0] e;
    string       nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if ({cout, sum} !== e) begin
          errors++;
          $display("FAIL %s got cout=%0b sum=%h expected cout=%0b sum=%h",
                   nm, cout, sum, e[16], e[15:0]);
        end
      end
    end
  end

  initial begin : driver
    int          tops[5];
    logic [16:0] ones;
    logic [15:0] ra, rb;
    tops = '{1, 3, 6, 10, 15};

    drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), "reset0");
    drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), "reset1");

    drive(1'b0, 16'h001F, 16'h000C, 1'b0, "dir_001F_000C");
    drive(1'b0, 16'hC61F, 16'h018C, 1'b1, "dir_C61F_018C");
    drive(1'b0, 16'hFFFF, 16'h0000, 1'b1, "dir_full_ripple");
    drive(1'b0, 16'h9249, 16'h9249, 1'b1, "dir_9249");
    drive(1'b0, 16'h0000, 16'h0000, 1'b0, "zero");
    drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, "max");

    // Carries that terminate exactly at each group's top bit, or start there.
    foreach (tops[i]) begin
      ones = (17'd1 << (tops[i] + 1)) - 17'd1;
      drive(1'b0, ones[15:0], 16'h0000, 1'b1, $sformatf("bnd_cin_top%0d", tops[i]));
      drive(1'b0, ones[15:0], 16'h0001, 1'b0, $sformatf("bnd_b1_top%0d", tops[i]));
      ones = 17'd1 << tops[i];
      drive(1'b0, ones[15:0], ones[15:0], 1'b0, $sformatf("bnd_gen_top%0d", tops[i]));
    end

    for (int n = 0; n < 10000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 7 == 0) rb = ~ra;
      if (n == 5000) begin
        drive(1'b1, ra, rb, 1'($urandom), "reset_mid");
        ra = 16'($urandom);
      end
      drive(1'b0, ra, rb, 1'($urandom), "random");
    end

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d expected pending=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
